// File: rtl/cfg_regfile_shadow_pkg.sv
// rtl/cfg_regfile_shadow_pkg.sv - shared addresses, command codes and helpers for the config register file
package cfg_regfile_shadow_pkg;

    localparam logic [7:0]  CTRL_ADDR_DEF  = 8'h02;
    localparam logic [7:0]  CMD_ADDR_DEF   = 8'h03;
    localparam logic [7:0]  BASE_ADDR_DEF  = 8'h04;
    localparam logic [7:0]  SHADOW_OFS     = 8'h80;
    localparam logic [7:0]  RD_CNT_ADDR    = 8'hFE;
    localparam logic [7:0]  RD_STAT_ADDR   = 8'hFF;

    localparam logic [15:0] CMD_COMMIT     = 16'h00AA;
    localparam logic [15:0] CMD_DISCARD    = 16'h00CC;

    localparam logic [15:0] CTRL_TRG_ON    = 16'h0001;
    localparam logic [15:0] CTRL_TRG_OFF   = 16'h0000;
    localparam logic [15:0] CTRL_DT_ON     = 16'h0002;
    localparam logic [15:0] CTRL_DT_OFF    = 16'h0003;

    typedef enum logic [2:0] {
        WR_NONE,
        WR_CTRL,
        WR_CMD,
        WR_DATA,
        WR_UNMAPPED
    } wr_kind_e;

    function automatic logic [15:0] status_word(input logic pending, input logic [7:0] err_cnt);
        return {pending, 7'b0, err_cnt};
    endfunction

endpackage

// File: rtl/cfg_regfile_shadow_if.sv
// rtl/cfg_regfile_shadow_if.sv - write/read command bus between uplink decoder and config register file
interface cfg_regfile_shadow_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              wr_in;
    logic [ADDR_W-1:0] wr_addr_in;
    logic [DATA_W-1:0] data_in;
    logic              rd_in;
    logic [ADDR_W-1:0] rd_addr_in;
    logic [DATA_W-1:0] rd_data_out;
    logic              rd_valid_out;
    logic              rd_err_out;

    modport master (
        output wr_in, wr_addr_in, data_in, rd_in, rd_addr_in,
        input  rd_data_out, rd_valid_out, rd_err_out
    );

    modport slave (
        input  wr_in, wr_addr_in, data_in, rd_in, rd_addr_in,
        output rd_data_out, rd_valid_out, rd_err_out
    );
endinterface

// File: rtl/cmd_pulse_gen.sv
// rtl/cmd_pulse_gen.sv - fixed-length, non-retriggerable command pulse
module cmd_pulse_gen #(
    parameter int PULSE_LEN = 50
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic start_in,
    output logic pulse_out
);
    localparam int CNT_W = $clog2(PULSE_LEN + 1);

    logic [CNT_W-1:0] cnt_q;

    // A start while the count is running is dropped so the pulse never stretches.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end else if (start_in) begin
            cnt_q <= CNT_W'(PULSE_LEN);
        end
    end

    assign pulse_out = (cnt_q != '0);
endmodule

// File: rtl/cfg_regfile_shadow.sv
// rtl/cfg_regfile_shadow.sv - trigger-board config register file with shadow/commit banks, read-back and command pulses
module cfg_regfile_shadow
    import cfg_regfile_shadow_pkg::*;
#(
    parameter int                        DATA_W    = 16,
    parameter int                        ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]         CTRL_ADDR = ADDR_W'(CTRL_ADDR_DEF),
    parameter logic [ADDR_W-1:0]         CMD_ADDR  = ADDR_W'(CMD_ADDR_DEF),
    parameter logic [ADDR_W-1:0]         BASE_ADDR = ADDR_W'(BASE_ADDR_DEF),
    parameter int                        NUM_REGS  = 18,
    parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL  = '0,
    parameter int                        NUM_CMD   = 2,
    parameter logic [NUM_CMD*DATA_W-1:0] CMD_CODES = {16'h0060, 16'h0055},
    parameter int                        PULSE_LEN = 50
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    cfg_regfile_shadow_if.slave          bus,
    output logic [NUM_REGS*DATA_W-1:0]   cfg_active_out,
    output logic                         commit_pending_out,
    output logic [DATA_W-1:0]            ctrl_reg_out,
    output logic                         trg_enb_out,
    output logic                         data_trans_enb_out,
    output logic [NUM_CMD-1:0]           cmd_pulse_out,
    output logic [15:0]                  config_received_out,
    output logic [7:0]                   wr_err_cnt_out
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    if ((NUM_REGS < 1) ||
        (32'(BASE_ADDR) + 32'(SHADOW_OFS) + 32'(NUM_REGS) > 32'(RD_CNT_ADDR))) begin : g_bad_map
        $error("cfg_regfile_shadow: shadow read-back window overlaps status addresses");
    end

    logic [1:0]        rst_sync_q;
    logic              wr_en;
    logic [31:0]       wa;
    logic [31:0]       ra;
    wr_kind_e          wr_kind;
    logic [IDX_W-1:0]  wr_idx;
    logic              do_commit;
    logic              do_discard;

    logic [DATA_W-1:0] ctrl_q;
    logic [DATA_W-1:0] cmd_q;
    logic              trg_enb_q;
    logic              dt_enb_q;
    logic              pending_q;
    logic [15:0]       cfg_cnt_q;
    logic [7:0]        err_cnt_q;

    logic [DATA_W-1:0] active_arr [NUM_REGS];
    logic [DATA_W-1:0] shadow_arr [NUM_REGS];

    logic [IDX_W-1:0]  rd_act_idx;
    logic [IDX_W-1:0]  rd_shd_idx;
    logic [DATA_W-1:0] rd_word;
    logic              rd_miss;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              rd_err_q;

    // Reset assertion is immediate; release is held off two edges before writes count.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign wr_en = bus.wr_in & rst_sync_q[1];
    assign wa    = 32'(bus.wr_addr_in);
    assign ra    = 32'(bus.rd_addr_in);

    always_comb begin
        wr_kind = WR_NONE;
        wr_idx  = '0;
        if (wr_en) begin
            if (wa == 32'(CTRL_ADDR)) begin
                wr_kind = WR_CTRL;
            end else if (wa == 32'(CMD_ADDR)) begin
                wr_kind = WR_CMD;
            end else if ((wa >= 32'(BASE_ADDR)) && (wa < 32'(BASE_ADDR) + 32'(NUM_REGS))) begin
                wr_kind = WR_DATA;
                wr_idx  = IDX_W'(wa - 32'(BASE_ADDR));
            end else begin
                wr_kind = WR_UNMAPPED;
            end
        end
    end

    assign do_commit  = (wr_kind == WR_CMD) && (bus.data_in == DATA_W'(CMD_COMMIT));
    assign do_discard = (wr_kind == WR_CMD) && (bus.data_in == DATA_W'(CMD_DISCARD));

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_W-1:0] shadow_q;
        logic [DATA_W-1:0] active_q;
        logic              sel;

        assign sel = (wr_kind == WR_DATA) && (wr_idx == IDX_W'(i));

        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                shadow_q <= RST_VAL[i*DATA_W +: DATA_W];
                active_q <= RST_VAL[i*DATA_W +: DATA_W];
            end else begin
                if (sel) begin
                    shadow_q <= bus.data_in;
                end else if (do_discard) begin
                    shadow_q <= active_q;
                end
                if (do_commit) begin
                    active_q <= shadow_q;
                end
            end
        end

        assign active_arr[i]                       = active_q;
        assign shadow_arr[i]                       = shadow_q;
        assign cfg_active_out[i*DATA_W +: DATA_W]  = active_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ctrl_q    <= '0;
            cmd_q     <= '0;
            trg_enb_q <= 1'b0;
            dt_enb_q  <= 1'b0;
            pending_q <= 1'b0;
            cfg_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (wr_kind == WR_CTRL) begin
                ctrl_q <= bus.data_in;
                if (bus.data_in == DATA_W'(CTRL_TRG_ON))  trg_enb_q <= 1'b1;
                if (bus.data_in == DATA_W'(CTRL_TRG_OFF)) trg_enb_q <= 1'b0;
                if (bus.data_in == DATA_W'(CTRL_DT_ON))   dt_enb_q  <= 1'b1;
                if (bus.data_in == DATA_W'(CTRL_DT_OFF))  dt_enb_q  <= 1'b0;
            end
            if (wr_kind == WR_CMD) begin
                cmd_q <= bus.data_in;
            end
            if (wr_kind == WR_DATA) begin
                pending_q <= 1'b1;
            end else if (do_commit || do_discard) begin
                pending_q <= 1'b0;
            end
            case (wr_kind)
                WR_CTRL, WR_CMD, WR_DATA: cfg_cnt_q <= cfg_cnt_q + 16'd1;
                WR_UNMAPPED: begin
                    if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CMD; k++) begin : g_cmd
        logic start;
        assign start = (wr_kind == WR_CMD) && (bus.data_in == CMD_CODES[k*DATA_W +: DATA_W]);

        cmd_pulse_gen #(
            .PULSE_LEN (PULSE_LEN)
        ) u_pulse (
            .clk_in    (clk_in),
            .rst_n_in  (rst_n_in),
            .start_in  (start),
            .pulse_out (cmd_pulse_out[k])
        );
    end

    // Read-back sees register state before any write landing on the same edge.
    always_comb begin
        rd_word    = '0;
        rd_miss    = 1'b0;
        rd_act_idx = IDX_W'(ra - 32'(BASE_ADDR));
        rd_shd_idx = IDX_W'(ra - 32'(BASE_ADDR) - 32'(SHADOW_OFS));
        if (ra == 32'(CTRL_ADDR)) begin
            rd_word = ctrl_q;
        end else if (ra == 32'(CMD_ADDR)) begin
            rd_word = cmd_q;
        end else if ((ra >= 32'(BASE_ADDR)) && (ra < 32'(BASE_ADDR) + 32'(NUM_REGS))) begin
            rd_word = active_arr[rd_act_idx];
        end else if ((ra >= 32'(BASE_ADDR) + 32'(SHADOW_OFS)) &&
                     (ra <  32'(BASE_ADDR) + 32'(SHADOW_OFS) + 32'(NUM_REGS))) begin
            rd_word = shadow_arr[rd_shd_idx];
        end else if (ra == 32'(RD_CNT_ADDR)) begin
            rd_word = DATA_W'(cfg_cnt_q);
        end else if (ra == 32'(RD_STAT_ADDR)) begin
            rd_word = DATA_W'(status_word(pending_q, err_cnt_q));
        end else begin
            rd_miss = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_in;
            rd_err_q   <= bus.rd_in & rd_miss;
            if (bus.rd_in) begin
                rd_data_q <= rd_word;
            end
        end
    end

    assign bus.rd_data_out     = rd_data_q;
    assign bus.rd_valid_out    = rd_valid_q;
    assign bus.rd_err_out      = rd_err_q;

    assign commit_pending_out  = pending_q;
    assign ctrl_reg_out        = ctrl_q;
    assign trg_enb_out         = trg_enb_q;
    assign data_trans_enb_out  = dt_enb_q;
    assign config_received_out = cfg_cnt_q;
    assign wr_err_cnt_out      = err_cnt_q;
endmodule

// File: tb/tb_cfg_regfile_shadow.sv
// tb/tb_cfg_regfile_shadow.sv - directed scoreboard bench for cfg_regfile_shadow
module tb_cfg_regfile_shadow;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int NUM_REGS  = 18;
    localparam int NUM_CMD   = 2;
    localparam int PULSE_LEN = 50;
    localparam logic [7:0] A_CTRL = 8'h02;
    localparam logic [7:0] A_CMD  = 8'h03;
    localparam logic [7:0] A_BASE = 8'h04;

    typedef struct {
        logic [15:0] data;
        logic        err;
        string       tag;
    } rd_exp_t;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    always #10 clk_in = ~clk_in;

    cfg_regfile_shadow_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [NUM_REGS*DATA_W-1:0] cfg_active_out;
    logic                       commit_pending_out;
    logic [DATA_W-1:0]          ctrl_reg_out;
    logic                       trg_enb_out;
    logic                       data_trans_enb_out;
    logic [NUM_CMD-1:0]         cmd_pulse_out;
    logic [15:0]                config_received_out;
    logic [7:0]                 wr_err_cnt_out;

    cfg_regfile_shadow #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .NUM_CMD   (NUM_CMD),
        .PULSE_LEN (PULSE_LEN)
    ) dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .bus                 (bus),
        .cfg_active_out      (cfg_active_out),
        .commit_pending_out  (commit_pending_out),
        .ctrl_reg_out        (ctrl_reg_out),
        .trg_enb_out         (trg_enb_out),
        .data_trans_enb_out  (data_trans_enb_out),
        .cmd_pulse_out       (cmd_pulse_out),
        .config_received_out (config_received_out),
        .wr_err_cnt_out      (wr_err_cnt_out)
    );

    int checks = 0;
    int errors = 0;
    rd_exp_t sb[$];
    logic [15:0] last_rd = 16'h0;

    logic [15:0] m_shadow [NUM_REGS];
    logic [15:0] m_active [NUM_REGS];
    logic        m_pending, m_trg, m_dte;
    logic [15:0] m_ctrl, m_cmd, m_cfg;
    logic [7:0]  m_err;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_shadow[i] = 16'h0;
            m_active[i] = 16'h0;
        end
        m_pending = 1'b0; m_trg = 1'b0; m_dte = 1'b0;
        m_ctrl = 16'h0; m_cmd = 16'h0; m_cfg = 16'h0; m_err = 8'h0;
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [15:0] d);
        int ai;
        ai = int'(a);
        if (a == A_CTRL) begin
            m_ctrl = d;
            if (d == 16'h0001) m_trg = 1'b1;
            else if (d == 16'h0000) m_trg = 1'b0;
            else if (d == 16'h0002) m_dte = 1'b1;
            else if (d == 16'h0003) m_dte = 1'b0;
            m_cfg = m_cfg + 16'd1;
        end else if (a == A_CMD) begin
            m_cmd = d;
            if (d == 16'h00AA) begin
                for (int i = 0; i < NUM_REGS; i++) m_active[i] = m_shadow[i];
                m_pending = 1'b0;
            end else if (d == 16'h00CC) begin
                for (int i = 0; i < NUM_REGS; i++) m_shadow[i] = m_active[i];
                m_pending = 1'b0;
            end
            m_cfg = m_cfg + 16'd1;
        end else if (ai >= 4 && ai < 4 + NUM_REGS) begin
            m_shadow[ai-4] = d;
            m_pending = 1'b1;
            m_cfg = m_cfg + 16'd1;
        end else if (m_err != 8'hFF) begin
            m_err = m_err + 8'd1;
        end
    endfunction

    function automatic logic [16:0] model_read(input logic [7:0] a);
        int ai;
        ai = int'(a);
        if (a == A_CTRL) return {1'b0, m_ctrl};
        if (a == A_CMD) return {1'b0, m_cmd};
        if (ai >= 4 && ai < 4 + NUM_REGS) return {1'b0, m_active[ai-4]};
        if (ai >= 8'h84 && ai < 8'h84 + NUM_REGS) return {1'b0, m_shadow[ai-8'h84]};
        if (a == 8'hFE) return {1'b0, m_cfg};
        if (a == 8'hFF) return {1'b0, m_pending, 7'b0, m_err};
        return {1'b1, 16'h0};
    endfunction

    function automatic logic [NUM_REGS*DATA_W-1:0] m_active_packed();
        logic [NUM_REGS*DATA_W-1:0] r;
        for (int i = 0; i < NUM_REGS; i++) r[i*DATA_W +: DATA_W] = m_active[i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_rd(input string tag, input logic [7:0] a);
        rd_exp_t e;
        logic [16:0] r;
        r = model_read(a);
        e.data = r[15:0];
        e.err  = r[16];
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        bus.wr_in = 1'b1; bus.wr_addr_in = a; bus.data_in = d;
        step();
        bus.wr_in = 1'b0;
        model_write(a, d);
    endtask

    task automatic rd(input string tag, input logic [7:0] a);
        push_rd(tag, a);
        bus.rd_in = 1'b1; bus.rd_addr_in = a;
        step();
        bus.rd_in = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_active"},  cfg_active_out, m_active_packed());
        chk({tag, "_pending"}, commit_pending_out, m_pending);
        chk({tag, "_ctrl"},    ctrl_reg_out, m_ctrl);
        chk({tag, "_trg"},     trg_enb_out, m_trg);
        chk({tag, "_dte"},     data_trans_enb_out, m_dte);
        chk({tag, "_cfgcnt"},  config_received_out, m_cfg);
        chk({tag, "_errcnt"},  wr_err_cnt_out, m_err);
    endtask

    always @(negedge clk_in) begin
        rd_exp_t e;
        if (bus.rd_valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rd_unexpected_valid", bus.rd_valid_out, 1'b0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_data"}, bus.rd_data_out, e.data);
                chk({e.tag, "_err"},  bus.rd_err_out, e.err);
                last_rd = e.data;
            end
        end
    end

    initial begin
        logic [1:0] pe;
        bus.wr_in = 1'b0; bus.wr_addr_in = '0; bus.data_in = '0;
        bus.rd_in = 1'b0; bus.rd_addr_in = '0;
        model_reset();
        repeat (3) step();
        chk_state("t1_rst");
        chk("t1_rst_pulse", cmd_pulse_out, 2'b00);
        chk("t1_rst_rdvalid", bus.rd_valid_out, 1'b0);
        chk("t1_rst_rddata", bus.rd_data_out, 16'h0);

        // write issued right at release must be dropped by the synchroniser
        rst_n_in = 1'b1;
        bus.wr_in = 1'b1; bus.wr_addr_in = A_BASE; bus.data_in = 16'hDEAD;
        step();
        bus.wr_in = 1'b0;
        step();
        chk_state("t1_sync");
        rd("t1_status", 8'hFF);

        wr(A_BASE + 8'd1, 16'h1234);
        chk_state("t2_shadow_wr");
        rd("t2_shadow_rb", A_BASE + 8'h81);
        rd("t2_active_rb", A_BASE + 8'd1);
        wr(A_CMD, 16'h00AA);
        chk_state("t2_commit");
        rd("t2_cmd_rb", A_CMD);
        rd("t2_cnt_rb", 8'hFE);

        wr(A_BASE + 8'd5, 16'hBEEF);
        chk_state("t3_shadow_wr");
        push_rd("t3_rd_during_wr", A_BASE + 8'h85);
        bus.rd_in = 1'b1; bus.rd_addr_in = A_BASE + 8'h85;
        bus.wr_in = 1'b1; bus.wr_addr_in = A_BASE + 8'd5; bus.data_in = 16'h1111;
        step();
        bus.rd_in = 1'b0; bus.wr_in = 1'b0;
        model_write(A_BASE + 8'd5, 16'h1111);
        wr(A_CMD, 16'h00CC);
        chk_state("t3_discard");
        rd("t3_shadow5_rb", A_BASE + 8'h85);
        rd("t3_shadow1_rb", A_BASE + 8'h81);
        rd("t3_active1_rb", A_BASE + 8'd1);

        wr(A_CMD, 16'h0055);
        for (int c = 1; c <= 62; c++) begin
            pe[0] = (c <= PULSE_LEN);
            pe[1] = (c >= 11) && (c <= 10 + PULSE_LEN);
            chk($sformatf("t4_pulse_c%0d", c), cmd_pulse_out, pe);
            if (c == 10) begin
                bus.wr_in = 1'b1; bus.wr_addr_in = A_CMD; bus.data_in = 16'h0060;
                model_write(A_CMD, 16'h0060);
            end else if (c == 20) begin
                bus.wr_in = 1'b1; bus.wr_addr_in = A_CMD; bus.data_in = 16'h0055;
                model_write(A_CMD, 16'h0055);
            end else begin
                bus.wr_in = 1'b0;
            end
            step();
        end
        bus.wr_in = 1'b0;
        chk_state("t4_after");

        wr(A_CTRL, 16'h0001);
        wr(A_CTRL, 16'h0002);
        wr(A_CTRL, 16'h0007);
        chk_state("t5_ctrl7");
        wr(A_CTRL, 16'h0003);
        chk_state("t5_ctrl3");
        rd("t5_ctrl_rb", A_CTRL);

        wr(A_BASE + 8'd18, 16'h0F0F);
        wr(8'h01, 16'h0F0F);
        chk_state("t6_edge_unmapped");
        for (int i = 0; i < 300; i++) wr(8'h7F, 16'(i));
        chk_state("t6_err_sat");
        rd("t6_unmapped_rd", 8'h7F);
        rd("t6_status", 8'hFF);
        wr(A_BASE + 8'd17, 16'hA5A5);
        rd("t6_status_pend", 8'hFF);
        rd("t6_last_shadow", A_BASE + 8'h80 + 8'd17);
        rd("t6_last_active", A_BASE + 8'd17);
        wr(A_CMD, 16'h00AA);
        chk_state("t6_commit_last");
        step();
        step();
        chk("t6_rd_hold_data", bus.rd_data_out, last_rd);
        chk("t6_rd_hold_valid", bus.rd_valid_out, 1'b0);

        bus.wr_in = 1'b1; bus.wr_addr_in = A_CTRL; bus.data_in = 16'h0100;
        for (int i = 0; i < 65537; i++) begin
            step();
            model_write(A_CTRL, 16'h0100);
        end
        bus.wr_in = 1'b0;
        chk_state("t6_cfg_wrap");
        rd("t6_cnt_rb", 8'hFE);

        wr(A_CMD, 16'h0060);
        repeat (5) step();
        chk("t6_pulse_before_rst", cmd_pulse_out, 2'b10);
        rst_n_in = 1'b0;
        #2;
        model_reset();
        chk_state("t6_async_rst");
        chk("t6_rst_pulse", cmd_pulse_out, 2'b00);
        chk("t6_rst_rdvalid", bus.rd_valid_out, 1'b0);
        chk("t6_rst_rddata", bus.rd_data_out, 16'h0);
        step();
        chk("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
